// File: rtl/pll_reset_sequencer.sv
// Qualifies the rPLL lock, releases staged domain resets in order, and pulses
// the PLL RESET input when lock is not achieved within the timeout window.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned NUM_STAGES         = 3,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned PLL_RST_CYCLES     = 8,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic                  lock_sync,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    PLL_RST   = 3'd4
  } state_t;

  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GAP_W = $clog2(STAGE_GAP + 1);
  localparam int PR_W  = $clog2(PLL_RST_CYCLES + 1);
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOCK_TIMEOUT);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [PR_W-1:0]  PR_LAST  = PR_W'(PLL_RST_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

  logic                  sync1_q, sync2_q;
  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_q, to_d, to_inc;
  logic [ST_W-1:0]       stab_q, stab_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [PR_W-1:0]       prc_q, prc_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  timeout, qualified;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= WAIT_LOCK;
      to_q      <= '0;
      stab_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      prc_q     <= '0;
      rst_q     <= '1;
      ready_q   <= 1'b0;
      pll_rst_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      sync1_q   <= pll_lock;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      to_q      <= to_d;
      stab_q    <= stab_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      prc_q     <= prc_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
      pll_rst_q <= pll_rst_d;
      loss_q    <= loss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    stab_d    = stab_q;
    gap_d     = gap_q;
    stage_d   = stage_q;
    prc_d     = prc_q;
    rst_d     = rst_q;
    ready_d   = ready_q;
    pll_rst_d = 1'b0;
    loss_d    = loss_q;
    // Comparisons include the cycle being counted now, so transitions land on the Nth edge.
    to_inc    = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
    timeout   = (to_q >= TO_LAST);
    qualified = (stab_q >= ST_LAST);

    case (state_q)
      WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        to_d    = to_inc;
        if (sync2_q) begin
          state_d = STABLE;
          stab_d  = ST_W'(1);
        end else if (timeout) begin
          state_d   = PLL_RST;
          to_d      = '0;
          prc_d     = '0;
          pll_rst_d = 1'b1;
        end
      end

      STABLE: begin
        to_d = to_inc;
        if (sync2_q && qualified) begin
          gap_d   = '0;
          stage_d = STG_W'(1);
          if (NUM_STAGES == 1) begin
            rst_d   = '0;
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            rst_d[0] = 1'b0;
            state_d  = RELEASE;
          end
        end else if (timeout) begin
          state_d   = PLL_RST;
          to_d      = '0;
          prc_d     = '0;
          pll_rst_d = 1'b1;
        end else if (!sync2_q) begin
          state_d = WAIT_LOCK;
        end else begin
          stab_d = stab_q + ST_W'(1);
        end
      end

      RELEASE: begin
        if (sync2_q) begin
          if (gap_q == GAP_LAST) begin
            gap_d          = '0;
            rst_d[stage_q] = 1'b0;
            if (stage_q == STG_LAST) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      RUN: ;

      PLL_RST: begin
        pll_rst_d = 1'b1;
        prc_d     = prc_q + PR_W'(1);
        if (prc_q == PR_LAST) begin
          pll_rst_d = 1'b0;
          state_d   = WAIT_LOCK;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase

    // Lock lost after qualification: drop everything back into reset.
    if ((state_q == RELEASE || state_q == RUN) && !sync2_q) begin
      state_d = WAIT_LOCK;
      rst_d   = '1;
      ready_d = 1'b0;
      to_d    = '0;
      if (loss_q != {LOSS_CNT_W{1'b1}}) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end
  end

  assign pll_rst    = pll_rst_q;
  assign rst_out    = rst_q;
  assign ready      = ready_q;
  assign lock_sync  = sync2_q;
  assign loss_count = loss_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized checks of pll_reset_sequencer against a cycle-level
// reference model derived from the behavioural rules.
module tb_pll_reset_sequencer;

  localparam int LSC = 8;
  localparam int GAP = 4;
  localparam int N   = 3;
  localparam int TO  = 32;
  localparam int PRC = 4;
  localparam int LW  = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_lock = 1'b0;
  logic          pll_rst;
  logic [N-1:0]  rst_out;
  logic          ready;
  logic          lock_sync;
  logic [LW-1:0] loss_count;
  logic [2:0]    state;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP(GAP),
    .NUM_STAGES(N),
    .LOCK_TIMEOUT(TO),
    .PLL_RST_CYCLES(PRC),
    .LOSS_CNT_W(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .pll_rst(pll_rst),
    .rst_out(rst_out),
    .ready(ready),
    .lock_sync(lock_sync),
    .loss_count(loss_count),
    .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: mode uses the published debug encoding; release progress is
  // tracked as the age of the first release rather than a stage index.
  int m_s1 = 0, m_s2 = 0, m_mode = 0, m_to = 0, m_stab = 0, m_age = 0, m_prc = 0, m_loss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_rst();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      if (m_mode == 3)      r[k] = 1'b0;
      else if (m_mode == 2) r[k] = (m_age < k * GAP);
      else                  r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic m_lose();
    m_mode = 0;
    m_to   = 0;
    if (m_loss < LOSS_MAX) m_loss++;
  endtask

  task automatic model_edge();
    int ls;
    ls = m_s2;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_to = 0; m_stab = 0; m_age = 0; m_prc = 0; m_loss = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = int'(pll_lock);
    case (m_mode)
      0: begin
        m_to = (m_to + 1 > TO) ? TO : m_to + 1;
        if (ls != 0) begin
          m_mode = 1; m_stab = 1;
        end else if (m_to >= TO) begin
          m_mode = 4; m_to = 0; m_prc = 0;
        end
      end
      1: begin
        m_to = (m_to + 1 > TO) ? TO : m_to + 1;
        if (ls != 0 && m_stab + 1 >= LSC) begin
          m_age = 0; m_mode = (N == 1) ? 3 : 2;
        end else if (m_to >= TO) begin
          m_mode = 4; m_to = 0; m_prc = 0;
        end else if (ls == 0) begin
          m_mode = 0;
        end else begin
          m_stab++;
        end
      end
      2: begin
        if (ls == 0) m_lose();
        else begin
          m_age++;
          if (m_age >= (N - 1) * GAP) m_mode = 3;
        end
      end
      3: if (ls == 0) m_lose();
      default: begin
        m_prc++;
        if (m_prc >= PRC) m_mode = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("state",      32'(state),      32'(m_mode));
    check_eq("rst_out",    32'(rst_out),    32'(m_rst()));
    check_eq("ready",      32'(ready),      32'(m_mode == 3));
    check_eq("pll_rst",    32'(pll_rst),    32'(m_mode == 4));
    check_eq("lock_sync",  32'(lock_sync),  32'(m_s2));
    check_eq("loss_count", 32'(loss_count), 32'(m_loss));
  endtask

  task automatic tick(input logic rst_v, input logic lock_v);
    reset    = rst_v;
    pll_lock = lock_v;
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    edge_n = 0;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) tick(1'b0, 1'b1);
    check_eq("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic wait_rst(input logic [N-1:0] val, input int budget);
    for (int i = 0; i < budget && rst_out !== val; i++) tick(1'b0, 1'b1);
    check_eq("wait_rst", 32'(rst_out), 32'(val));
  endtask

  task automatic wait_state(input logic [2:0] val, input int budget);
    for (int i = 0; i < budget && state !== val; i++) tick(1'b0, 1'b1);
    check_eq("wait_state", 32'(state), 32'(val));
  endtask

  initial begin
    int cnt;
    logic lvl;
    int seg;

    // Clean lock: pll_lock first sampled high at edge 10.
    do_reset();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_rstout", 32'(rst_out), 32'h7);
    for (int e = 1; e <= 30; e++) begin
      tick(1'b0, e >= 10);
      if (edge_n == 10) check_eq("t1_sync_lat", 32'(lock_sync), 32'd0);
      if (edge_n == 11) check_eq("t1_sync", 32'(lock_sync), 32'd1);
      if (edge_n == 18) check_eq("t1_rst18", 32'(rst_out), 32'h7);
      if (edge_n == 19) check_eq("t1_rst19", 32'(rst_out), 32'h6);
      if (edge_n == 22) check_eq("t1_rst22", 32'(rst_out), 32'h6);
      if (edge_n == 23) check_eq("t1_rst23", 32'(rst_out), 32'h4);
      if (edge_n == 26) check_eq("t1_rdy26", 32'(ready), 32'd0);
      if (edge_n == 27) check_eq("t1_rst27", 32'(rst_out), 32'h0);
      if (edge_n == 27) check_eq("t1_rdy27", 32'(ready), 32'd1);
      if (edge_n >= 1) check_eq("t1_nopllrst", 32'(pll_rst), 32'd0);
    end

    // Flicker during qualification.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b1);
      if (lock_sync) cnt++; else cnt = 0;
      if (i >= 3 && cnt <= 8) check_eq("t2_hold", 32'(rst_out), 32'h7);
    end
    check_eq("t2_loss", 32'(loss_count), 32'd0);
    check_eq("t2_ready", 32'(ready), 32'd1);

    // No lock: periodic PLL reset pulses.
    do_reset();
    for (int e = 1; e <= 80; e++) begin
      tick(1'b0, 1'b0);
      check_eq("t3_pllrst", 32'(pll_rst), 32'(e >= 32 && ((e - 32) % 36) < 4));
      check_eq("t3_rstout", 32'(rst_out), 32'h7);
    end

    // Losses in RUN, saturating the counter.
    do_reset();
    wait_ready(60);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      check_eq("t4_rst", 32'(rst_out), 32'h7);
      check_eq("t4_rdy", 32'(ready), 32'd0);
      check_eq("t4_loss", 32'(loss_count), 32'((i + 1 > 3) ? 3 : i + 1));
      wait_ready(60);
    end
    check_eq("t4_sat", 32'(loss_count), 32'd3);

    // Loss mid-release, then reset mid-release.
    do_reset();
    wait_rst(3'b110, 60);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check_eq("t5_rst", 32'(rst_out), 32'h7);
    check_eq("t5_loss", 32'(loss_count), 32'd1);
    wait_state(3'd2, 60);
    tick(1'b1, 1'b1);
    check_eq("t6_state", 32'(state), 32'd0);
    check_eq("t6_rst", 32'(rst_out), 32'h7);
    check_eq("t6_loss", 32'(loss_count), 32'd0);
    check_eq("t6_sync", 32'(lock_sync), 32'd0);
    check_eq("t6_ready", 32'(ready), 32'd0);

    // Randomized lock behaviour with occasional resets.
    lvl = 1'b0;
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lvl = ~lvl;
        seg = lvl ? $urandom_range(1, 60) : $urandom_range(1, 50);
      end
      seg--;
      tick($urandom_range(0, 299) == 0, lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
